btn_pulse_gen: RTL and testbench
================================

Name: btn_pulse_gen

Overview:
- Conditions one raw push-button input into a clean single-cycle pulse and a debounced level.
- Sits directly upstream of the VGA theme controller; `pulse` drives its `chg` input, so one physical press advances the theme exactly once.
- Contains a 2-FF synchronizer, a debounce FSM and a one-pulse generator, with optional auto-repeat while the button is held.

Parameters:
- DB_CYCLES, 1000000, stable-sample count required to accept a press or release (10 ms at 100 MHz); legal range ≥ 2.
- CNT_W, 20, debounce counter width; must satisfy 2^CNT_W > DB_CYCLES.
- REPEAT_DELAY, 50000000, HELD cycles before the first auto-repeat pulse (macro-gated).
- REPEAT_PERIOD, 20000000, cycles between subsequent auto-repeat pulses (macro-gated).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- btn  input  1  raw asynchronous push-button, active-high
- pulse  output  1  one-cycle strobe per accepted press; to theme controller `chg`
- level  output  1  debounced button state

Behaviour:
- Reset (rst=0, asynchronous):
  - sync FFs = 0, state = IDLE, counters = 0, pulse = 0, level = 0.
  - Reset mid-debounce or mid-hold discards all progress; no pulse is emitted on reset release.
- Synchronizer: btn → s1 → s2 (`btn_s`); all FSM decisions use `btn_s` only.
- States and transitions:
  - IDLE: `btn_s`=1 → DB_PRESS, cnt=0.
  - DB_PRESS:
    - `btn_s`=0 → IDLE (glitch rejected, no pulse).
    - Otherwise cnt++. When cnt==DB_CYCLES-1, next edge → HELD.
  - HELD: `btn_s`=0 → DB_RELEASE, cnt=0.
  - DB_RELEASE:
    - `btn_s`=1 → HELD (bounce on release; no new pulse).
    - Otherwise cnt++. When cnt==DB_CYCLES-1, next edge → IDLE.
- Outputs (both registered):
  - pulse = 1 for exactly the first cycle in HELD when entered from DB_PRESS. Re-entry from DB_RELEASE produces no pulse.
  - level = 1 in HELD and DB_RELEASE, 0 otherwise.
- Latency: with btn stable high from edge 1, pulse is high after edge DB_CYCLES+3 for one cycle. A release is accepted DB_CYCLES+3 edges after btn falls.
- Counter rules:
  - cnt never exceeds DB_CYCLES-1 and never wraps.
  - cnt is cleared on every state change.
- Any btn activity shorter than DB_CYCLES stable samples never produces a pulse.
- Back-to-back presses: a new pulse requires a full return to IDLE first.

Optional Feature:
- Macro: BTN_AUTOREPEAT_EN.
- Defined:
  - A repeat counter `rcnt` runs while in HELD and clears on leaving HELD.
  - Extra one-cycle pulse when `rcnt` reaches REPEAT_DELAY, then every REPEAT_PERIOD cycles while still in HELD.
  - DB_RELEASE freezes and clears `rcnt`; bouncing back to HELD restarts the delay.
- Undefined: `rcnt` logic absent; exactly one pulse per accepted press regardless of hold time.

Decomposition:
- Shared package `btn_pkg`:
  - 2-bit state encoding localparams: IDLE=2'b00, DB_PRESS=2'b01, HELD=2'b10, DB_RELEASE=2'b11.
  - Default DB_CYCLES and REPEAT_* constants, reused by other button instances (theme, mode buttons).
- Sub-module `btn_sync`: 2-FF synchronizer, async active-low reset to 0. Separate so timing constraints can target it.

Test Plan (DB_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8):
- Reset: hold rst=0 with btn=1 for 10 cycles → pulse=0, level=0; release rst with btn held → pulse after edge 7 from release, once.
- Clean press: btn 0→1 held 30 cycles → pulse high exactly 1 cycle at edge 7; level=1 from edge 7; level=0 at edge 7 after btn falls.
- Glitch: btn high 3 cycles then low → pulse never asserts, level stays 0, state back to IDLE.
- Release bounce: while HELD, btn low 2 cycles, high, low steady → no second pulse; level stays 1 until the steady-low debounce completes.
- Mid-operation reset: assert rst during DB_PRESS (cnt=2) → immediately idle; pulse=0; a subsequent clean press gives exactly one pulse.
- BTN_AUTOREPEAT_EN: hold btn 60 cycles after first pulse → extra pulses 20, 28, 36, 44, 52 cycles after HELD entry; with the macro undefined → only the first pulse.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared button-conditioning types and default timing constants,
// reused by every push-button instance (theme, mode, ...).
package btn_pkg;

   typedef enum logic [1:0] {
      IDLE       = 2'b00,
      DB_PRESS   = 2'b01,
      HELD       = 2'b10,
      DB_RELEASE = 2'b11
   } btn_state_t;

   // 10 ms debounce, 0.5 s first repeat, 0.2 s repeat period at 100 MHz
   localparam int unsigned DB_CYCLES_DEF     = 1000000;
   localparam int unsigned CNT_W_DEF         = 20;
   localparam int unsigned REPEAT_DELAY_DEF  = 50000000;
   localparam int unsigned REPEAT_PERIOD_DEF = 20000000;

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchronizer for the raw button; kept as its own module so
// timing constraints can target the metastability flops by name.
module btn_sync (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic s1;
   logic s2;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s1 <= d;
         s2 <= s1;
      end
   end

   assign q = s2;

endmodule

// File: rtl/btn_pulse_gen.sv
// Push-button conditioner: synchronizer, debounce FSM, one-pulse output.
// Define BTN_AUTOREPEAT_EN to add auto-repeat pulses while the button is held.
module btn_pulse_gen
   import btn_pkg::*;
#(
   parameter int unsigned DB_CYCLES     = DB_CYCLES_DEF,
   parameter int unsigned CNT_W         = CNT_W_DEF,
   parameter int unsigned REPEAT_DELAY  = REPEAT_DELAY_DEF,
   parameter int unsigned REPEAT_PERIOD = REPEAT_PERIOD_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic pulse,
   output logic level
);

   if (DB_CYCLES < 2 || (64'd1 << CNT_W) <= 64'(DB_CYCLES)) begin : g_bad_db
      $error("btn_pulse_gen: need DB_CYCLES >= 2 and 2**CNT_W > DB_CYCLES");
   end
   if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_rpt
      $error("btn_pulse_gen: REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
   end

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

`ifdef BTN_AUTOREPEAT_EN
   localparam int unsigned RCNT_W = $clog2(REPEAT_DELAY + REPEAT_PERIOD);
   localparam logic [RCNT_W-1:0] RPT_PRE   = RCNT_W'(REPEAT_DELAY - 1);
   localparam logic [RCNT_W-1:0] RPT_START = RCNT_W'(REPEAT_DELAY);
   localparam logic [RCNT_W-1:0] RPT_WRAP  = RCNT_W'(REPEAT_DELAY + REPEAT_PERIOD - 1);
   logic [RCNT_W-1:0] rcnt;
`endif

   logic             btn_s;
   btn_state_t       state;
   logic [CNT_W-1:0] cnt;

   btn_sync u_sync (
      .clk (clk),
      .rst (rst),
      .d   (btn),
      .q   (btn_s)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         cnt   <= '0;
         pulse <= 1'b0;
         level <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
         rcnt  <= '0;
`endif
      end else begin
         pulse <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
         rcnt  <= '0;
`endif
         case (state)
            IDLE: begin
               if (btn_s) begin
                  state <= DB_PRESS;
                  cnt   <= '0;
               end
            end
            DB_PRESS: begin
               if (!btn_s) begin
                  state <= IDLE;
                  cnt   <= '0;
               end else if (cnt == CNT_LAST) begin
                  state <= HELD;
                  cnt   <= '0;
                  pulse <= 1'b1;
                  level <= 1'b1;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            HELD: begin
               if (!btn_s) begin
                  state <= DB_RELEASE;
                  cnt   <= '0;
               end
`ifdef BTN_AUTOREPEAT_EN
               // rcnt parks at REPEAT_DELAY after each pulse so it never needs to run past one period
               else if (rcnt == RPT_WRAP) begin
                  rcnt  <= RPT_START;
                  pulse <= 1'b1;
               end else begin
                  rcnt  <= rcnt + RCNT_W'(1);
                  pulse <= (rcnt == RPT_PRE);
               end
`endif
            end
            DB_RELEASE: begin
               if (btn_s) begin
                  state <= HELD;
                  cnt   <= '0;
               end else if (cnt == CNT_LAST) begin
                  state <= IDLE;
                  cnt   <= '0;
                  level <= 1'b0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_btn_pulse_gen.sv
// Self-checking bench for btn_pulse_gen against a sliding-window reference
// model; honours BTN_AUTOREPEAT_EN when it is defined for the build.
module tb_btn_pulse_gen;

   localparam int DB = 4;
   localparam int RD = 20;
   localparam int RP = 8;

   logic clk = 1'b0;
   logic rst;
   logic btn;
   logic pulse;
   logic level;

   int checks = 0;
   int errors = 0;

   // reference model: btn_s is btn two samples late; a level flips after
   // DB+1 consecutive samples disagreeing with it
   logic dq[$];
   int   ones;
   int   zeros;
   int   hrun;
   logic m_level;
   logic m_pulse;
   logic m_held;

   always #5 clk = ~clk;

   btn_pulse_gen #(
      .DB_CYCLES    (DB),
      .CNT_W        (3),
      .REPEAT_DELAY (RD),
      .REPEAT_PERIOD(RP)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .btn   (btn),
      .pulse (pulse),
      .level (level)
   );

   task automatic model_reset();
      dq = '{1'b0, 1'b0};
      ones = 0;
      zeros = 0;
      hrun = 0;
      m_level = 1'b0;
      m_pulse = 1'b0;
      m_held = 1'b0;
   endtask

   task automatic model_edge(input logic b);
      logic bs;
      logic was_held;
      dq.push_back(b);
      bs = dq.pop_front();
      if (bs) begin ones++; zeros = 0; end
      else begin zeros++; ones = 0; end
      m_pulse = 1'b0;
      was_held = m_held;
      if (!m_level && ones >= DB + 1) begin
         m_level = 1'b1;
         m_pulse = 1'b1;
      end else if (m_level && zeros >= DB + 1) begin
         m_level = 1'b0;
      end
      m_held = m_level && bs;
      hrun = (m_held && was_held) ? hrun + 1 : 0;
`ifdef BTN_AUTOREPEAT_EN
      if (m_held && hrun >= RD && (hrun - RD) % RP == 0) m_pulse = 1'b1;
`endif
   endtask

   // called positioned on a negedge; returns on the following negedge
   task automatic cyc(input logic b);
      btn = b;
      @(posedge clk);
      model_edge(b);
      @(negedge clk);
   endtask

   task automatic test_reset();
      int first;
      int npulse;
      @(negedge clk);
      rst = 1'b0;
      btn = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checks += 2;
         if (pulse !== 1'b0) begin errors++; $display("FAIL reset_pulse cyc %0d got %b exp 0", i, pulse); end
         if (level !== 1'b0) begin errors++; $display("FAIL reset_level cyc %0d got %b exp 0", i, level); end
      end
      rst = 1'b1;
      model_reset();
      first = -1;
      npulse = 0;
      for (int i = 1; i <= 12; i++) begin
         cyc(1'b1);
         checks += 2;
         if (pulse !== m_pulse) begin errors++; $display("FAIL rstrel_pulse edge %0d got %b exp %b", i, pulse, m_pulse); end
         if (level !== m_level) begin errors++; $display("FAIL rstrel_level edge %0d got %b exp %b", i, level, m_level); end
         if (pulse === 1'b1) begin npulse++; if (first < 0) first = i; end
      end
      checks += 2;
      if (first != 7) begin errors++; $display("FAIL rstrel_first_edge got %0d exp 7", first); end
      if (npulse != 1) begin errors++; $display("FAIL rstrel_count got %0d exp 1", npulse); end
      for (int i = 1; i <= 10; i++) begin
         cyc(1'b0);
         checks += 2;
         if (pulse !== m_pulse) begin errors++; $display("FAIL rstrel_off_pulse edge %0d got %b exp %b", i, pulse, m_pulse); end
         if (level !== m_level) begin errors++; $display("FAIL rstrel_off_level edge %0d got %b exp %b", i, level, m_level); end
      end
   endtask

   task automatic test_clean_press();
      int first_p;
      int npulse;
      int fall;
      first_p = -1;
      npulse = 0;
      for (int i = 1; i <= 30; i++) begin
         cyc(1'b1);
         checks += 2;
         if (pulse !== m_pulse) begin errors++; $display("FAIL press_pulse edge %0d got %b exp %b", i, pulse, m_pulse); end
         if (level !== m_level) begin errors++; $display("FAIL press_level edge %0d got %b exp %b", i, level, m_level); end
         if (pulse === 1'b1 && first_p < 0) first_p = i;
         if (pulse === 1'b1 && i <= 10) npulse++;
      end
      checks += 2;
      if (first_p != 7) begin errors++; $display("FAIL press_first_edge got %0d exp 7", first_p); end
      if (npulse != 1) begin errors++; $display("FAIL press_width got %0d exp 1", npulse); end
      fall = -1;
      for (int i = 1; i <= 12; i++) begin
         cyc(1'b0);
         checks += 2;
         if (pulse !== m_pulse) begin errors++; $display("FAIL release_pulse edge %0d got %b exp %b", i, pulse, m_pulse); end
         if (level !== m_level) begin errors++; $display("FAIL release_level edge %0d got %b exp %b", i, level, m_level); end
         if (level === 1'b0 && fall < 0) fall = i;
      end
      checks++;
      if (fall != 7) begin errors++; $display("FAIL release_fall_edge got %0d exp 7", fall); end
   endtask

   task automatic test_glitch();
      int npulse;
      int nlevel;
      npulse = 0;
      nlevel = 0;
      for (int i = 1; i <= 13; i++) begin
         cyc(i <= 3 ? 1'b1 : 1'b0);
         checks += 2;
         if (pulse !== m_pulse) begin errors++; $display("FAIL glitch_pulse edge %0d got %b exp %b", i, pulse, m_pulse); end
         if (level !== m_level) begin errors++; $display("FAIL glitch_level edge %0d got %b exp %b", i, level, m_level); end
         if (pulse !== 1'b0) npulse++;
         if (level !== 1'b0) nlevel++;
      end
      checks += 2;
      if (npulse != 0) begin errors++; $display("FAIL glitch_no_pulse got %0d exp 0", npulse); end
      if (nlevel != 0) begin errors++; $display("FAIL glitch_no_level got %0d exp 0", nlevel); end
   endtask

   task automatic test_release_bounce();
      logic bounce[3];
      int npulse;
      int fall;
      bounce = '{1'b0, 1'b0, 1'b1};
      for (int i = 1; i <= 10; i++) begin
         cyc(1'b1);
         checks += 2;
         if (pulse !== m_pulse) begin errors++; $display("FAIL bnc_press_pulse edge %0d got %b exp %b", i, pulse, m_pulse); end
         if (level !== m_level) begin errors++; $display("FAIL bnc_press_level edge %0d got %b exp %b", i, level, m_level); end
      end
      npulse = 0;
      for (int i = 0; i < 3; i++) begin
         cyc(bounce[i]);
         checks += 2;
         if (pulse !== 1'b0) begin errors++; $display("FAIL bnc_pulse step %0d got %b exp 0", i, pulse); end
         if (level !== 1'b1) begin errors++; $display("FAIL bnc_level step %0d got %b exp 1", i, level); end
      end
      fall = -1;
      for (int i = 1; i <= 12; i++) begin
         cyc(1'b0);
         checks += 2;
         if (pulse !== m_pulse) begin errors++; $display("FAIL bnc_low_pulse edge %0d got %b exp %b", i, pulse, m_pulse); end
         if (level !== m_level) begin errors++; $display("FAIL bnc_low_level edge %0d got %b exp %b", i, level, m_level); end
         if (pulse === 1'b1) npulse++;
         if (level === 1'b0 && fall < 0) fall = i;
      end
      checks += 2;
      if (npulse != 0) begin errors++; $display("FAIL bnc_second_pulse got %0d exp 0", npulse); end
      if (fall != 7) begin errors++; $display("FAIL bnc_fall_edge got %0d exp 7", fall); end
   endtask

   task automatic test_mid_reset();
      int npulse;
      for (int i = 1; i <= 5; i++) cyc(1'b1);
      rst = 1'b0;
      #1;
      checks += 2;
      if (pulse !== 1'b0) begin errors++; $display("FAIL midrst_pulse got %b exp 0", pulse); end
      if (level !== 1'b0) begin errors++; $display("FAIL midrst_level got %b exp 0", level); end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      model_reset();
      npulse = 0;
      for (int i = 1; i <= 30; i++) begin
         cyc((i > 3 && i <= 18) ? 1'b1 : 1'b0);
         checks += 2;
         if (pulse !== m_pulse) begin errors++; $display("FAIL midrst_pulse edge %0d got %b exp %b", i, pulse, m_pulse); end
         if (level !== m_level) begin errors++; $display("FAIL midrst_level edge %0d got %b exp %b", i, level, m_level); end
         if (pulse === 1'b1) npulse++;
      end
      checks++;
      if (npulse != 1) begin errors++; $display("FAIL midrst_count got %0d exp 1", npulse); end
   endtask

   task automatic test_autorepeat();
      int exp_q[$];
      int got_q[$];
      exp_q = '{7};
`ifdef BTN_AUTOREPEAT_EN
      exp_q = '{7, 27, 35, 43, 51, 59};
`endif
      for (int i = 1; i <= 65; i++) begin
         cyc(1'b1);
         checks += 2;
         if (pulse !== m_pulse) begin errors++; $display("FAIL rpt_pulse edge %0d got %b exp %b", i, pulse, m_pulse); end
         if (level !== m_level) begin errors++; $display("FAIL rpt_level edge %0d got %b exp %b", i, level, m_level); end
         if (pulse === 1'b1) got_q.push_back(i);
      end
      checks++;
      if (got_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL rpt_count got %0d exp %0d", got_q.size(), exp_q.size());
      end
      for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
         checks++;
         if (got_q[k] != exp_q[k]) begin errors++; $display("FAIL rpt_edge[%0d] got %0d exp %0d", k, got_q[k], exp_q[k]); end
      end
      for (int i = 1; i <= 12; i++) begin
         cyc(1'b0);
         checks += 2;
         if (pulse !== m_pulse) begin errors++; $display("FAIL rpt_off_pulse edge %0d got %b exp %b", i, pulse, m_pulse); end
         if (level !== m_level) begin errors++; $display("FAIL rpt_off_level edge %0d got %b exp %b", i, level, m_level); end
      end
   endtask

   task automatic test_random();
      logic b;
      int run;
      b = 1'b0;
      run = 0;
      for (int i = 1; i <= 600; i++) begin
         if (run == 0) begin
            b = ~b;
            run = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 40)) : int'($urandom_range(1, 7));
         end
         run--;
         cyc(b);
         checks += 2;
         if (pulse !== m_pulse) begin errors++; $display("FAIL rand_pulse cyc %0d got %b exp %b", i, pulse, m_pulse); end
         if (level !== m_level) begin errors++; $display("FAIL rand_level cyc %0d got %b exp %b", i, level, m_level); end
      end
   endtask

   initial begin
      rst = 1'b0;
      btn = 1'b1;
      model_reset();
      test_reset();
      test_clean_press();
      test_glitch();
      test_release_bounce();
      test_mid_reset();
      test_autorepeat();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
